// File: rtl/condicionador_controles.sv
// Input conditioner for the drone game: synchronises, debounces and decodes six raw
// board buttons into direction levels and single-cycle confirm/start pulses.
module condicionador_controles #(
  parameter int DEBOUNCE_CICLOS = 50000,
  parameter int ATIVO_BAIXO     = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       botao_cima,
  input  logic       botao_baixo,
  input  logic       botao_esquerda,
  input  logic       botao_direita,
  input  logic       botao_confirma,
  input  logic       botao_iniciar,
  output logic [1:0] controle_vertical,
  output logic [1:0] controle_horizontal,
  output logic       confirma,
  output logic       iniciar,
  output logic [5:0] db_estavel
);

  localparam int NB = 6;
  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  // Accept on the edge where the count would become DEBOUNCE_CICLOS.
  localparam logic [CW-1:0] C_LIMITE = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [CW-1:0] C_UM     = CW'(1);
  localparam logic [CW-1:0] C_ZERO   = CW'(0);

  // Bit order everywhere: {iniciar, confirma, direita, esquerda, baixo, cima}.
  logic [NB-1:0] w_bruto;
  logic [NB-1:0] w_ativo;
  logic [NB-1:0] r_sinc1;
  logic [NB-1:0] r_sinc2;
  logic [NB-1:0] r_estavel;
  logic [CW-1:0] r_cont [NB];
  logic [1:0]    r_anterior;
  logic [1:0]    r_pulso;

  assign w_bruto = {botao_iniciar, botao_confirma, botao_direita,
                    botao_esquerda, botao_baixo, botao_cima};
  assign w_ativo = (ATIVO_BAIXO != 0) ? ~w_bruto : w_bruto;

  // Two-flop synchroniser per button.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sinc1 <= 6'b000000;
      r_sinc2 <= 6'b000000;
    end else begin
      r_sinc1 <= w_ativo;
      r_sinc2 <= r_sinc1;
    end
  end

  // Debounce: a synced value must disagree with the stable bit on consecutive edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estavel <= 6'b000000;
      for (int i = 0; i < NB; i++) begin
        r_cont[i] <= C_ZERO;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (r_sinc2[i] == r_estavel[i]) begin
          r_cont[i] <= C_ZERO;
        end else if (r_cont[i] == C_LIMITE) begin
          r_estavel[i] <= r_sinc2[i];
          r_cont[i]    <= C_ZERO;
        end else begin
          r_cont[i] <= r_cont[i] + C_UM;
        end
      end
    end
  end

  // Rising-edge detect on the debounced confirm/start bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_anterior <= 2'b00;
      r_pulso    <= 2'b00;
    end else begin
      r_anterior <= r_estavel[5:4];
      r_pulso    <= r_estavel[5:4] & ~r_anterior;
    end
  end

  // Opposite buttons pressed together cancel out to "none".
  assign controle_vertical   = {r_estavel[1] & ~r_estavel[0], r_estavel[0] & ~r_estavel[1]};
  assign controle_horizontal = {r_estavel[2] & ~r_estavel[3], r_estavel[3] & ~r_estavel[2]};
  assign confirma            = r_pulso[0];
  assign iniciar             = r_pulso[1];
  assign db_estavel          = r_estavel;

endmodule

// File: tb/tb_condicionador_controles.sv
// Bench for condicionador_controles: cycle model feeds a scoreboard queue, plus directed
// latency and pulse-count checks for the main scenarios.
module tb_condicionador_controles;

  logic       clock;
  logic       reset;
  logic       botao_cima, botao_baixo, botao_esquerda, botao_direita;
  logic       botao_confirma, botao_iniciar;
  logic [1:0] controle_vertical, controle_horizontal;
  logic       confirma, iniciar;
  logic [5:0] db_estavel;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] sb_q[$];

  logic [5:0] m_s1, m_s2, m_est;
  logic [1:0] m_ant, m_pul;
  logic [3:0] m_hist [6];

  condicionador_controles #(.DEBOUNCE_CICLOS(4), .ATIVO_BAIXO(0)) dut (
    .clock              (clock),
    .reset              (reset),
    .botao_cima         (botao_cima),
    .botao_baixo        (botao_baixo),
    .botao_esquerda     (botao_esquerda),
    .botao_direita      (botao_direita),
    .botao_confirma     (botao_confirma),
    .botao_iniciar      (botao_iniciar),
    .controle_vertical  (controle_vertical),
    .controle_horizontal(controle_horizontal),
    .confirma           (confirma),
    .iniciar            (iniciar),
    .db_estavel         (db_estavel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] eixo(input logic pos, input logic neg);
    case ({pos, neg})
      2'b10:   eixo = 2'b01;
      2'b01:   eixo = 2'b10;
      default: eixo = 2'b00;
    endcase
  endfunction

  // Reference: stable flips once the last four synced samples all disagree with it.
  always @(posedge clock) begin
    logic [5:0] raw;
    logic [5:0] est_novo;
    if (!reset) begin
      m_s1 = 6'b0; m_s2 = 6'b0; m_est = 6'b0; m_ant = 2'b0; m_pul = 2'b0;
      for (int b = 0; b < 6; b++) m_hist[b] = 4'b0;
    end else begin
      raw = {botao_iniciar, botao_confirma, botao_direita, botao_esquerda, botao_baixo, botao_cima};
      est_novo = m_est;
      for (int b = 0; b < 6; b++) begin
        m_hist[b] = {m_hist[b][2:0], m_s2[b]};
        if (m_hist[b] == {4{~m_est[b]}}) est_novo[b] = ~m_est[b];
      end
      m_pul = m_est[5:4] & ~m_ant;
      m_ant = m_est[5:4];
      m_est = est_novo;
      m_s2  = m_s1;
      m_s1  = raw;
    end
    sb_q.push_back({m_est, eixo(m_est[0], m_est[1]), eixo(m_est[3], m_est[2]), m_pul[0], m_pul[1]});
  end

  always @(posedge clock) begin
    logic [11:0] exp;
    #1;
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      check_value("saidas", {db_estavel, controle_vertical, controle_horizontal, confirma, iniciar}, exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_pulsos;
    int borda;
    reset = 1'b0;
    {botao_iniciar, botao_confirma, botao_direita, botao_esquerda, botao_baixo, botao_cima} = 6'b111111;

    // 1. reset with every button high
    repeat (5) @(negedge clock);
    check_value("reset_estavel", {26'b0, db_estavel}, 32'h0);
    check_value("reset_saidas", {26'b0, controle_vertical, controle_horizontal, confirma, iniciar}, 32'h0);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check_value("todos_estaveis", {26'b0, db_estavel}, 32'h3f);
    {botao_iniciar, botao_confirma, botao_direita, botao_esquerda, botao_baixo, botao_cima} = 6'b000000;
    repeat (20) @(negedge clock);

    // 2. up press and release latency
    botao_cima = 1'b1;
    repeat (5) @(posedge clock);
    #1 check_value("cima_borda5", {30'b0, controle_vertical}, 32'h0);
    @(posedge clock);
    #1 check_value("cima_borda6", {30'b0, controle_vertical}, 32'h1);
    repeat (14) @(negedge clock);
    botao_cima = 1'b0;
    repeat (5) @(posedge clock);
    #1 check_value("solta_borda5", {30'b0, controle_vertical}, 32'h1);
    @(posedge clock);
    #1 check_value("solta_borda6", {30'b0, controle_vertical}, 32'h0);
    repeat (5) @(negedge clock);

    // 3. short bounces on down are rejected
    for (int r = 0; r < 4; r++) begin
      @(negedge clock);
      botao_baixo = 1'b1;
      repeat (3) begin
        @(posedge clock);
        #1 check_value("baixo_curto", {28'b0, controle_vertical, confirma, iniciar}, 32'h0);
      end
      @(negedge clock);
      botao_baixo = 1'b0;
    end
    repeat (8) begin
      @(posedge clock);
      #1 check_value("baixo_ignorado", {30'b0, controle_vertical}, 32'h0);
    end

    // 4. confirm held: exactly one pulse at edge 7
    @(negedge clock);
    botao_confirma = 1'b1;
    n_pulsos = 0; borda = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clock);
      #1;
      if (confirma) begin
        n_pulsos++;
        if (borda == 0) borda = c;
      end
    end
    check_value("confirma_pulsos", n_pulsos, 32'd1);
    check_value("confirma_borda", borda, 32'd7);
    @(negedge clock);
    botao_confirma = 1'b0;
    repeat (10) @(negedge clock);

    // 5. opposite buttons cancel, orthogonal axis independent
    botao_cima = 1'b1; botao_baixo = 1'b1; botao_direita = 1'b1;
    repeat (12) @(negedge clock);
    check_value("oposto_vertical", {30'b0, controle_vertical}, 32'h0);
    check_value("direita_horiz", {30'b0, controle_horizontal}, 32'h1);
    botao_baixo = 1'b0;
    repeat (5) @(posedge clock);
    #1 check_value("oposto_borda5", {30'b0, controle_vertical}, 32'h0);
    @(posedge clock);
    #1 check_value("oposto_borda6", {30'b0, controle_vertical}, 32'h1);
    check_value("horiz_inalterado", {30'b0, controle_horizontal}, 32'h1);
    @(negedge clock);
    botao_cima = 1'b0; botao_direita = 1'b0;
    repeat (10) @(negedge clock);

    // 6. start held across a mid-debounce reset
    botao_iniciar = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1 check_value("reset_meio_estavel", {26'b0, db_estavel}, 32'h0);
    check_value("reset_meio_iniciar", {31'b0, iniciar}, 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    n_pulsos = 0; borda = 0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clock);
      #1;
      if (iniciar) begin
        n_pulsos++;
        if (borda == 0) borda = c;
      end
    end
    check_value("iniciar_pulsos", n_pulsos, 32'd1);
    check_value("iniciar_borda", borda, 32'd7);
    @(negedge clock);
    botao_iniciar = 1'b0;
    repeat (12) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
